// File: rtl/demux_ctrl_pkg.sv
// Shared constants and types for the demux routing controller.
package demux_ctrl_pkg;

    // Routing modes as presented on the mode input
    localparam logic [1:0] MODE_ALT   = 2'b00;
    localparam logic [1:0] MODE_BURST = 2'b01;
    localparam logic [1:0] MODE_FIXED = 2'b10;

    // Channel identifiers, also the demux select values
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // The reserved mode encoding behaves exactly like alternate mode.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ALT : m;
    endfunction

endpackage

// File: rtl/demux.sv
// The team's 8-bit 1:2 demux: the selected output carries the input, the other is 0.
module demux (
    input  logic [7:0] Data_in,
    input  logic       sel,
    output logic [7:0] Data_out_0,
    output logic [7:0] Data_out_1
);

    assign Data_out_0 = sel ? 8'h00 : Data_in;
    assign Data_out_1 = sel ? Data_in : 8'h00;

endmodule

// File: rtl/demux_route_pick.sv
// Destination channel choice for the byte being accepted this cycle.
module demux_route_pick
    import demux_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic [1:0] mode,
    input  logic       force_sel,
    input  logic [1:0] ch_en,
    input  logic       last_ch,
    input  logic       burst_ch,
    input  logic [7:0] burst_cnt,
    output logic       chan
);

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    logic want;

    // Preferred channel by mode, then steer away from a disabled channel.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        want = ~last_ch;
        chan = 1'b0;
        unique case (norm_mode(mode))
            MODE_BURST: want = (burst_cnt >= BURST_MAX) ? ~burst_ch : burst_ch;
            MODE_FIXED: want = force_sel;
            default:    want = ~last_ch;
        endcase
        chan = want;
        if (!ch_en[want] && ch_en[~want]) begin
            chan = ~want;
        end
    end

endmodule

// File: rtl/demux_route_ctrl.sv
// Holds one byte from the upstream handshake and delivers it to one of two
// consumers through the demux, with per-channel delivered-byte counters.
module demux_route_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [1:0]       mode,
    input  logic             force_sel,
    input  logic [1:0]       ch_en,
    input  logic             cnt_clr,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [7:0]       out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [7:0]       out1_data,
    output logic             cur_sel,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t           state_q, state_d;
    logic [7:0]       hold_q;
    logic             sel_q;
    logic             last_ch_q;
    logic             burst_ch_q;
    logic [7:0]       burst_cnt_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic             fire, accept, pick_ch;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    assign busy     = (state_q == HOLD);
    assign fire     = busy & (sel_q ? out1_ready : out0_ready);
    // Ready depends on the consumer ready and enables only, never on in_valid.
    assign in_ready = rst_n & (|ch_en) & (~busy | fire);
    assign accept   = in_valid & in_ready;

    assign out0_valid = busy & (sel_q == CH0);
    assign out1_valid = busy & (sel_q == CH1);
    assign cur_sel    = sel_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

    demux_route_pick #(
        .BURST_LEN (BURST_LEN)
    ) u_pick (
        .mode      (mode),
        .force_sel (force_sel),
        .ch_en     (ch_en),
        .last_ch   (last_ch_q),
        .burst_ch  (burst_ch_q),
        .burst_cnt (burst_cnt_q),
        .chan      (pick_ch)
    );

    demux u_demux (
        .Data_in    (hold_q),
        .sel        (sel_q),
        .Data_out_0 (out0_data),
        .Data_out_1 (out1_data)
    );

    // Next state: take a byte when empty, release it on fire unless refilled.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (fire && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Held byte and its channel; the byte is zeroed once delivered so idle outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 8'h00;
            sel_q  <= CH0;
        end else if (accept) begin
            hold_q <= in_data;
            sel_q  <= pick_ch;
        end else if (fire) begin
            hold_q <= 8'h00;
        end
    end

    // Routing history: last channel used and burst position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ch_q   <= CH1;
            burst_ch_q  <= CH0;
            burst_cnt_q <= 8'd0;
        end else begin
            if (accept) last_ch_q <= pick_ch;
            if (norm_mode(mode) != MODE_BURST) begin
                burst_cnt_q <= 8'd0;
                burst_ch_q  <= accept ? pick_ch : last_ch_q;
            end else if (accept) begin
                if (pick_ch == burst_ch_q && burst_cnt_q < BURST_MAX) begin
                    burst_cnt_q <= burst_cnt_q + 8'd1;
                end else begin
                    burst_ch_q  <= pick_ch;
                    burst_cnt_q <= 8'd1;
                end
            end
        end
    end

    // Delivered-byte counters; a clear pulse overrides a same-cycle fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (cnt_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (fire) begin
            if (sel_q == CH0) cnt0_q <= cnt0_q + 1'b1;
            else              cnt1_q <= cnt1_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl with per-channel expected-byte queues.
module tb_demux_route_ctrl;

    localparam int TB_CNT_W = 10;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid, in_ready;
    logic [7:0]          in_data;
    logic [1:0]          mode;
    logic                force_sel;
    logic [1:0]          ch_en;
    logic                cnt_clr;
    logic                out0_valid, out0_ready, out1_valid, out1_ready;
    logic [7:0]          out0_data, out1_data;
    logic                cur_sel, busy;
    logic [TB_CNT_W-1:0] cnt0, cnt1;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    demux_route_ctrl #(
        .BURST_LEN (4),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode       (mode),
        .force_sel  (force_sel),
        .ch_en      (ch_en),
        .cnt_clr    (cnt_clr),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cur_sel    (cur_sel),
        .busy       (busy),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte, wait (bounded) for acceptance, record where it must appear.
    task automatic send(input logic [7:0] b, input logic ch, output int stalls);
        in_valid = 1'b1;
        in_data  = b;
        stalls   = 0;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        check("accept_timeout", 32'(in_ready), 32'd1);
        if (in_ready) begin
            if (ch) q1.push_back(b);
            else    q0.push_back(b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(busy), 32'd0);
        check("q0_left", 32'(q0.size()), 32'd0);
        check("q1_left", 32'(q1.size()), 32'd0);
    endtask

    // Scoreboard: every delivery must match the oldest expected byte of its channel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) check("ch0_unexpected", 32'(out0_data), 32'hFFFF_FFFF);
                else                check("ch0_data", 32'(out0_data), 32'(q0.pop_front()));
                check("ch1_idle_data", 32'(out1_data), 32'd0);
                check("ch1_idle_valid", 32'(out1_valid), 32'd0);
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) check("ch1_unexpected", 32'(out1_data), 32'hFFFF_FFFF);
                else                check("ch1_data", 32'(out1_data), 32'(q1.pop_front()));
                check("ch0_idle_data", 32'(out0_data), 32'd0);
                check("ch0_idle_valid", 32'(out0_valid), 32'd0);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mode = 2'b00;
        force_sel = 1'b0; ch_en = 2'b11; cnt_clr = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out0_data", 32'(out0_data), 32'd0);
        check("rst_out1_data", 32'(out1_data), 32'd0);
        check("rst_cur_sel", 32'(cur_sel), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Alternate mode, back-to-back
        mode = 2'b00;
        send(8'h11, 1'b0, st); check("alt_stall0", 32'(st), 32'd0);
        send(8'h22, 1'b1, st); check("alt_stall1", 32'(st), 32'd0);
        send(8'h33, 1'b0, st); check("alt_stall2", 32'(st), 32'd0);
        send(8'h44, 1'b1, st); check("alt_stall3", 32'(st), 32'd0);
        drain();
        check("alt_cnt0", 32'(cnt0), 32'd2);
        check("alt_cnt1", 32'(cnt1), 32'd2);

        // One fixed byte to ch0 so the burst starts on ch0
        mode = 2'b10; force_sel = 1'b0;
        send(8'h01, 1'b0, st);
        drain();

        // Burst mode: 4 to ch0, 4 to ch1, then ch0 again
        mode = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), (i >= 5 && i <= 8), st);
            check("burst_stall", 32'(st), 32'd0);
        end
        drain();
        check("burst_cnt0", 32'(cnt0), 32'd9);
        check("burst_cnt1", 32'(cnt1), 32'd6);

        // Fixed ch1 requested but disabled: goes to ch0
        mode = 2'b10; force_sel = 1'b1; ch_en = 2'b01;
        send(8'hA5, 1'b0, st);
        drain();
        check("fixed_cnt0", 32'(cnt0), 32'd10);
        check("fixed_cnt1", 32'(cnt1), 32'd6);

        // Both channels disabled: nothing accepted
        ch_en = 2'b00; in_valid = 1'b1; in_data = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dis_in_ready", 32'(in_ready), 32'd0);
            check("dis_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; ch_en = 2'b11;

        // Backpressure on ch1
        out1_ready = 1'b0;
        send(8'h5C, 1'b1, st);
        in_valid = 1'b1; in_data = 8'h6D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out1_valid", 32'(out1_valid), 32'd1);
            check("bp_out1_data", 32'(out1_data), 32'h5C);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out0_data", 32'(out0_data), 32'd0);
            check("bp_out0_valid", 32'(out0_valid), 32'd0);
        end
        @(posedge clk); #1;
        out1_ready = 1'b1;
        send(8'h6D, 1'b1, st);
        check("bp_same_cycle", 32'(st), 32'd0);
        check("bp_next_busy", 32'(busy), 32'd1);
        check("bp_next_data", 32'(out1_data), 32'h6D);
        drain();
        check("bp_cnt1", 32'(cnt1), 32'd8);

        // Reset while holding a ch0 byte (alternate, last used ch1 -> ch0)
        mode = 2'b00; out0_ready = 1'b0;
        send(8'h77, 1'b0, st);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out0_valid", 32'(out0_valid), 32'd0);
        check("arst_out1_valid", 32'(out1_valid), 32'd0);
        check("arst_cnt0", 32'(cnt0), 32'd0);
        check("arst_cnt1", 32'(cnt1), 32'd0);
        q0.delete();
        q1.delete();
        out0_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out0_valid | out1_valid), 32'd0);
        send(8'h88, 1'b0, st);
        drain();
        check("post_rst_cnt0", 32'(cnt0), 32'd1);
        check("post_rst_cnt1", 32'(cnt1), 32'd0);

        // Counter wrap on ch0
        mode = 2'b10; force_sel = 1'b0;
        for (int i = 0; i < 1022; i++) send(8'(i), 1'b0, st);
        drain();
        check("wrap_pre", 32'(cnt0), 32'h3FF);
        send(8'hC3, 1'b0, st);
        drain();
        check("wrap_zero", 32'(cnt0), 32'd0);

        // Clear wins over a same-cycle fire
        send(8'hD1, 1'b0, st);
        send(8'hD2, 1'b0, st);
        check("clr_pre", 32'(cnt0), 32'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("clr_cnt0", 32'(cnt0), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
Sequencing controller for the team's 8-bit 1:2 demux. It accepts a byte stream over a valid/ready handshake and holds one byte. It picks the destination channel by routing mode and drives the demux select. It presents the byte to one of two consumers with per-channel valid/ready and keeps per-channel delivered-byte counters. It sits between the upstream byte source and the two downstream consumers.

Parameters:
- BURST_LEN, 4: bytes sent to one channel before switching in burst mode; legal range 1..255.
- CNT_W, 16: width of each delivered-byte counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream byte valid
- in_ready  out  1  controller can accept a byte this cycle
- in_data  in  8  upstream byte
- mode  in  2  routing mode: 00 alternate, 01 burst, 10 fixed, 11 reserved (treated as 00)
- force_sel  in  1  destination channel in fixed mode
- ch_en  in  2  per-channel enable mask; bit0 = ch0, bit1 = ch1
- cnt_clr  in  1  synchronous pulse that clears both counters
- out0_valid  out  1  ch0 byte valid
- out0_ready  in  1  ch0 consumer ready
- out0_data  out  8  ch0 byte; 0 when ch0 is not selected
- out1_valid  out  1  ch1 byte valid
- out1_ready  in  1  ch1 consumer ready
- out1_data  out  8  ch1 byte; 0 when ch1 is not selected
- cur_sel  out  1  current demux select (channel of the held byte)
- busy  out  1  a byte is held
- cnt0  out  CNT_W  bytes delivered on ch0
- cnt1  out  CNT_W  bytes delivered on ch1

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; in_ready 0 while rst_n is low; all out*_valid 0; out*_data 0; cur_sel 0; busy 0; cnt0 and cnt1 0; last_ch 1 (so the first alternate-mode byte goes to ch0); burst channel 0; burst count 0.
- State machine:
  - IDLE: no byte held.
  - HOLD: one byte held in hold_q, channel in sel_q.
- Transitions:
  - IDLE -> HOLD on accept.
  - HOLD -> IDLE on fire with no new accept.
  - HOLD -> HOLD on fire with a simultaneous accept (back-to-back, one byte per cycle sustained).
- Definitions:
  - fire = outN_valid & outN_ready for N = sel_q.
  - accept = in_valid & in_ready.
- in_ready rule: in_ready = (IDLE or fire) and at least one ch_en bit set. in_ready is combinational from outN_ready; there is no combinational path from in_valid to in_ready.
- Latency: a byte accepted in cycle t has outN_valid high from cycle t+1. outN_valid stays high, with data stable, until fire.
- Output drive: sel_q drives the demux select. The non-selected channel has valid 0 and data 0.
- Channel choice is computed at accept:
  - Alternate: chosen channel = !last_ch.
  - Burst: stay on the burst channel until BURST_LEN bytes have been accepted on it, then switch; the burst count restarts at 0 on each switch.
  - Fixed: chosen channel = force_sel.
- Enable override:
  - If the chosen channel is disabled and the other is enabled, the byte goes to the other channel.
  - last_ch and the burst channel then update to the channel actually used.
  - If both channels are disabled, in_ready is 0.
- ch_en changes while in HOLD do not reroute the held byte; it waits for its assigned consumer.
- Mode changes:
  - A mode change takes effect at the next accept.
  - While mode is not burst, the burst count is held at 0 and the burst channel follows last_ch.
- Counters:
  - cntN increments on each fire of channel N and wraps modulo 2^CNT_W.
  - If cnt_clr is high in the same cycle as a fire, clear wins and the counter becomes 0.
- busy = (state == HOLD).
- Reset mid-transfer discards the held byte. No output is asserted until the next accept after reset is released.

Decomposition:
- Package demux_ctrl_pkg:
  - mode constants MODE_ALT = 2'b00, MODE_BURST = 2'b01, MODE_FIXED = 2'b10.
  - state encoding: IDLE, HOLD.
  - channel constants CH0 = 0, CH1 = 1.
- Sub-module: instantiates the team's existing 8-bit 1:2 demux (module demux). hold_q drives Data_in, sel_q drives sel, and Data_out_0/1 drive out0_data/out1_data. The combinational select logic may also be factored into a sub-module, demux_route_pick.

Test Plan:
- Alternate mode, both channels enabled, both readies high, bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> ch0 gets 0x11 and 0x33, ch1 gets 0x22 and 0x44; one byte per cycle; cnt0 = 2, cnt1 = 2.
- Burst mode, BURST_LEN = 4, 10 bytes streamed -> ch0 gets bytes 1-4, ch1 gets bytes 5-8, ch0 gets bytes 9-10.
- Fixed mode, force_sel = 1, ch_en = 2'b01, byte 0xA5 -> 0xA5 routed to ch0, cnt0 increments; with ch_en = 2'b00, in_ready stays 0 for 10 cycles and busy stays 0.
- Backpressure: out1_ready low for 5 cycles while holding 0x5C -> out1_valid high and out1_data = 0x5C stable throughout; in_ready 0; out0_data = 0; fire and new accept occur in the same cycle once ready rises.
- Reset: rst_n pulsed low asynchronously during HOLD -> out*_valid, busy and counters go to 0 immediately; the held byte is never delivered; the first post-reset alternate-mode byte goes to ch0.
- Counters: cnt0 preloaded near 0xFFFF by streaming -> wraps to 0x0000; cnt_clr asserted in the same cycle as a ch0 fire -> cnt0 = 0.
